// File: rtl/load_writeback_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : load_writeback_unit_if
// Description : Load request, data-memory and register-file write signals.
// Revision    : 1.0  initial release
// ============================================================================
interface load_writeback_unit_if;
   logic        Start;
   logic [2:0]  Funct3;
   logic [31:0] Addr;
   logic [4:0]  Rd;
   logic        Busy;
   logic        MemReq;
   logic [31:0] MemAddr;
   logic        MemAck;
   logic [31:0] MemRData;
   logic        RegW;
   logic [4:0]  DR;
   logic [31:0] Reg_In;
   logic        Fault;

   modport master (
      input  Start, Funct3, Addr, Rd, MemAck, MemRData,
      output Busy, MemReq, MemAddr, RegW, DR, Reg_In, Fault
   );

   modport slave (
      output Start, Funct3, Addr, Rd, MemAck, MemRData,
      input  Busy, MemReq, MemAddr, RegW, DR, Reg_In, Fault
   );
endinterface
`default_nettype wire

// File: rtl/load_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_writeback_unit
// Description : Multi-cycle load: word read via req/ack, lane extract, RF write.
// Revision    : 1.0  initial release
// ============================================================================
module load_writeback_unit #(
   parameter int TIMEOUT = 16,
   parameter int XLEN    = 32
) (
   input  wire logic              CLK,
   input  wire logic              RST_N,
   load_writeback_unit_if.master  bus
);

   generate
      if (XLEN != 32) begin : g_xlen_check
         $error("load_writeback_unit supports XLEN=32 only");
      end
      if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_check
         $error("load_writeback_unit TIMEOUT must be in 1..255");
      end
   endgenerate

   localparam logic [1:0] c_S_IDLE = 2'd0;
   localparam logic [1:0] c_S_REQ  = 2'd1;
   localparam logic [1:0] c_S_WB   = 2'd2;
   localparam logic [1:0] c_S_FLT  = 2'd3;

   localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

   logic [1:0]  r_state;
   logic [1:0]  r_addr_lo;
   logic [2:0]  r_funct3;
   logic [4:0]  r_rd;
   logic [7:0]  r_cnt;
   logic        r_memreq;
   logic [31:0] r_memaddr;
   logic        r_regw;
   logic [4:0]  r_dr;
   logic [31:0] r_reg_in;
   logic        r_fault;

   logic        w_bad;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_ext;

   // Misalignment / illegal-code decode on the live request inputs.
   always_comb begin
      w_bad = 1'b0;
      case (bus.Funct3)
         3'b000, 3'b100: w_bad = 1'b0;
         3'b001, 3'b101: w_bad = bus.Addr[0];
         3'b010:         w_bad = (bus.Addr[1:0] != 2'b00);
         default:        w_bad = 1'b1;
      endcase
   end

   always_comb begin
      w_byte = bus.MemRData[7:0];
      case (r_addr_lo)
         2'd0: w_byte = bus.MemRData[7:0];
         2'd1: w_byte = bus.MemRData[15:8];
         2'd2: w_byte = bus.MemRData[23:16];
         2'd3: w_byte = bus.MemRData[31:24];
         default: w_byte = bus.MemRData[7:0];
      endcase
      w_half = r_addr_lo[1] ? bus.MemRData[31:16] : bus.MemRData[15:0];
      case (r_funct3)
         3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_ext = {24'd0, w_byte};
         3'b001:  w_ext = {{16{w_half[15]}}, w_half};
         3'b101:  w_ext = {16'd0, w_half};
         default: w_ext = bus.MemRData;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state   <= c_S_IDLE;
         r_addr_lo <= 2'd0;
         r_funct3  <= 3'd0;
         r_rd      <= 5'd0;
         r_cnt     <= 8'd0;
         r_memreq  <= 1'b0;
         r_memaddr <= 32'd0;
         r_regw    <= 1'b0;
         r_dr      <= 5'd0;
         r_reg_in  <= 32'd0;
         r_fault   <= 1'b0;
      end else begin
         r_regw  <= 1'b0;
         r_fault <= 1'b0;
         case (r_state)
            c_S_IDLE: begin
               if (bus.Start) begin
                  r_addr_lo <= bus.Addr[1:0];
                  r_funct3  <= bus.Funct3;
                  r_rd      <= bus.Rd;
                  if (w_bad) begin
                     r_state <= c_S_FLT;
                     r_fault <= 1'b1;
                  end else begin
                     r_state   <= c_S_REQ;
                     r_memreq  <= 1'b1;
                     r_memaddr <= {bus.Addr[31:2], 2'b00};
                     r_cnt     <= 8'd0;
                  end
               end
            end
            c_S_REQ: begin
               // An ack on the final allowed cycle wins over the timeout.
               if (bus.MemAck) begin
                  r_reg_in <= w_ext;
                  r_dr     <= r_rd;
                  r_regw   <= (r_rd != 5'd0);
                  r_memreq <= 1'b0;
                  r_state  <= c_S_WB;
               end else if (r_cnt == c_CNT_LAST) begin
                  r_memreq <= 1'b0;
                  r_fault  <= 1'b1;
                  r_state  <= c_S_FLT;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            c_S_WB:  r_state <= c_S_IDLE;
            c_S_FLT: r_state <= c_S_IDLE;
            default: r_state <= c_S_IDLE;
         endcase
      end
   end

   assign bus.Busy    = (r_state != c_S_IDLE);
   assign bus.MemReq  = r_memreq;
   assign bus.MemAddr = r_memaddr;
   assign bus.RegW    = r_regw;
   assign bus.DR      = r_dr;
   assign bus.Reg_In  = r_reg_in;
   assign bus.Fault   = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_load_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_writeback_unit
// Description : Scoreboard bench for load_writeback_unit with directed loads.
// Revision    : 1.0  initial release
// ============================================================================
module tb_load_writeback_unit;

   logic CLK;
   logic RST_N;

   load_writeback_unit_if bus ();

   load_writeback_unit #(.TIMEOUT(4), .XLEN(32)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct packed {
      logic        fault;
      logic [4:0]  dr;
      logic [31:0] val;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   req_issued = 0;
   int   req_cycles = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every write or fault pulse.
   initial begin : monitor
      logic prev_req;
      exp_t e;
      prev_req = 1'b0;
      forever begin
         @(negedge CLK);
         if (bus.MemReq) req_cycles++;
         if (bus.MemReq && !prev_req) req_issued++;
         prev_req = bus.MemReq;
         if (bus.RegW || bus.Fault) begin
            if (q.size() == 0) begin
               chk("unexpected pulse {RegW,Fault}", {30'd0, bus.RegW, bus.Fault}, 32'd0);
            end else begin
               e = q.pop_front();
               if (e.fault) begin
                  chk("fault pulse {RegW,Fault}", {30'd0, bus.RegW, bus.Fault}, 32'd1);
               end else begin
                  chk("write pulse {RegW,Fault}", {30'd0, bus.RegW, bus.Fault}, 32'd2);
                  chk("write DR", {27'd0, bus.DR}, {27'd0, e.dr});
                  chk("write Reg_In", bus.Reg_In, e.val);
               end
            end
         end
      end
   end

   // ack_cyc: REQ cycle on which MemAck is driven (0 = never).
   task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [4:0] rd, input int ack_cyc, input logic [31:0] data,
                           input logic [31:0] exp_val, input bit exp_mem, input bit exp_fault,
                           input bit extra_start, input int exp_req_cycles);
      int r0;
      int c0;
      int n;
      r0 = req_issued;
      c0 = req_cycles;
      if (exp_fault) q.push_back('{1'b1, 5'd0, 32'd0});
      else if (rd != 5'd0) q.push_back('{1'b0, rd, exp_val});
      @(negedge CLK);
      bus.Start  = 1'b1;
      bus.Funct3 = f3;
      bus.Addr   = a;
      bus.Rd     = rd;
      @(negedge CLK);
      bus.Start = 1'b0;
      chk({tag, " MemReq after start"}, 32'(bus.MemReq), 32'(exp_mem));
      if (exp_mem) begin
         chk({tag, " MemAddr"}, bus.MemAddr, {a[31:2], 2'b00});
         n = 1;
         while (bus.MemReq && n <= 20) begin
            if (extra_start && n == 1) bus.Start = 1'b1;
            if (n == ack_cyc) begin
               bus.MemAck   = 1'b1;
               bus.MemRData = data;
            end
            @(negedge CLK);
            bus.Start  = 1'b0;
            bus.MemAck = 1'b0;
            n++;
         end
         chk({tag, " MemReq released"}, 32'(bus.MemReq), 32'd0);
      end
      chk({tag, " Busy in WB/FLT"}, 32'(bus.Busy), 32'd1);
      @(negedge CLK);
      chk({tag, " Busy after"}, 32'(bus.Busy), 32'd0);
      chk({tag, " requests issued"}, 32'(req_issued - r0), exp_mem ? 32'd1 : 32'd0);
      if (exp_req_cycles >= 0)
         chk({tag, " MemReq cycles"}, 32'(req_cycles - c0), 32'(exp_req_cycles));
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin : stim
      RST_N        = 1'b0;
      bus.Start    = 1'b0;
      bus.Funct3   = 3'd0;
      bus.Addr     = 32'd0;
      bus.Rd       = 5'd0;
      bus.MemAck   = 1'b0;
      bus.MemRData = 32'd0;
      repeat (3) @(negedge CLK);
      chk("reset Busy", 32'(bus.Busy), 32'd0);
      chk("reset MemReq", 32'(bus.MemReq), 32'd0);
      chk("reset {RegW,Fault}", {30'd0, bus.RegW, bus.Fault}, 32'd0);
      chk("reset MemAddr", bus.MemAddr, 32'd0);
      chk("reset DR", {27'd0, bus.DR}, 32'd0);
      chk("reset Reg_In", bus.Reg_In, 32'd0);
      RST_N = 1'b1;
      @(negedge CLK);

      // Aligned word load, ack on third REQ cycle
      run_load("lw", 3'b010, 32'h0000_0100, 5'd5, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 0, 0, 3);

      // Byte/halfword lanes of 0x80FF7F01
      run_load("lb203",  3'b000, 32'h0000_0203, 5'd1, 1, 32'h80FF_7F01, 32'hFFFF_FF80, 1, 0, 0, 1);
      run_load("lbu203", 3'b100, 32'h0000_0203, 5'd2, 2, 32'h80FF_7F01, 32'h0000_0080, 1, 0, 0, 2);
      run_load("lb201",  3'b000, 32'h0000_0201, 5'd3, 1, 32'h80FF_7F01, 32'h0000_007F, 1, 0, 0, 1);
      run_load("lhu202", 3'b101, 32'h0000_0202, 5'd4, 1, 32'h80FF_7F01, 32'h0000_80FF, 1, 0, 0, 1);
      run_load("lh202",  3'b001, 32'h0000_0202, 5'd6, 2, 32'h80FF_7F01, 32'hFFFF_80FF, 1, 0, 0, 2);
      run_load("lb200",  3'b000, 32'h0000_0200, 5'd7, 1, 32'h80FF_7F01, 32'h0000_0001, 1, 0, 0, 1);

      // Faults without memory access
      run_load("lw102",  3'b010, 32'h0000_0102, 5'd8, 0, 32'd0, 32'd0, 0, 1, 0, 0);
      run_load("lh101",  3'b001, 32'h0000_0101, 5'd8, 0, 32'd0, 32'd0, 0, 1, 0, 0);
      run_load("f3_011", 3'b011, 32'h0000_0100, 5'd8, 0, 32'd0, 32'd0, 0, 1, 0, 0);

      // Timeout, and ack on the final allowed cycle
      run_load("timeout", 3'b010, 32'h0000_0400, 5'd9, 0, 32'd0, 32'd0, 1, 1, 0, 4);
      run_load("ack4",    3'b010, 32'h0000_0404, 5'd9, 4, 32'h1234_5678, 32'h1234_5678, 1, 0, 0, 4);

      // x0 destination and Start while busy
      run_load("x0",    3'b010, 32'h0000_0500, 5'd0, 1, 32'hCAFE_F00D, 32'd0, 1, 0, 0, 1);
      run_load("busy2", 3'b010, 32'h0000_0600, 5'd10, 3, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 1, 0, 1, 3);

      // Asynchronous reset in the middle of REQ
      @(negedge CLK);
      bus.Start  = 1'b1;
      bus.Funct3 = 3'b010;
      bus.Addr   = 32'h0000_0300;
      bus.Rd     = 5'd11;
      @(negedge CLK);
      bus.Start = 1'b0;
      chk("rst-mid MemReq before", 32'(bus.MemReq), 32'd1);
      @(negedge CLK);
      #2 RST_N = 1'b0;
      #1;
      chk("rst-mid MemReq", 32'(bus.MemReq), 32'd0);
      chk("rst-mid Busy", 32'(bus.Busy), 32'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      repeat (6) @(negedge CLK);
      chk("rst-mid idle after", 32'(bus.Busy), 32'd0);

      run_load("post_rst", 3'b010, 32'h0000_0700, 5'd12, 2, 32'h5555_AAAA, 32'h5555_AAAA, 1, 0, 0, 2);

      repeat (3) @(negedge CLK);
      chk("scoreboard drained", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/load_writeback_unit.md
Name: load_writeback_unit

Overview:
- Multi-cycle load unit feeding the register file's write port (RegW, DR, Reg_In).
- Takes a decoded load (address, funct3, destination register) and issues a word read to data memory with a req/ack handshake.
- Extracts and extends the addressed byte, halfword or word, then presents it to the register file as a one-cycle write.
- Detects misaligned or illegal loads and memory timeouts, and reports them as faults with no register write.

Parameters:
- TIMEOUT, 16: max cycles in REQ without MemAck before a fault; legal range 1..255.
- XLEN, 32: data and address width; the design is fixed at 32 and the value is checked only.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle load request; sampled only in IDLE.
- Funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; all other codes are illegal.
- Addr  input  32  byte address.
- Rd  input  5  destination register.
- Busy  output  1  high in any state other than IDLE.
- MemReq  output  1  memory read request.
- MemAddr  output  32  word-aligned address {Addr_q[31:2],2'b00}.
- MemAck  input  1  memory data valid; meaningful only while MemReq=1.
- MemRData  input  32  memory read data, little-endian.
- RegW  output  1  register-file write enable, one-cycle pulse.
- DR  output  5  register-file destination.
- Reg_In  output  32  register-file write data.
- Fault  output  1  one-cycle pulse on misalign, illegal funct3 or timeout.

Behaviour:
- **Reset (RST_N=0, async):**
  - state=IDLE.
  - Busy, MemReq, RegW and Fault are 0.
  - MemAddr, DR and Reg_In are 0; the timeout counter is 0.
  - Reset mid-operation abandons the load: MemReq drops immediately and no write or fault follows.
- **All outputs are registered** (no combinational path from an input to an output).
- **States:** IDLE, REQ, WB, FLT.
- **IDLE:**
  - On Start=1, latch Addr, Funct3 and Rd.
  - Misaligned (LH/LHU with Addr[0]=1, LW with Addr[1:0]!=0) or illegal Funct3: go to FLT.
  - Otherwise: go to REQ with MemReq=1 and MemAddr set on the same edge.
- **REQ:**
  - MemReq is held at 1 and MemAddr is held stable.
  - Each cycle without MemAck, the counter increments.
  - MemAck=1: capture the extracted data into Reg_In and Rd into DR, drop MemReq, go to WB.
  - Counter reaches TIMEOUT-1 with no ack: drop MemReq, go to FLT. An ack arriving on that same cycle takes priority over the timeout.
- **WB:**
  - RegW=1 for exactly one cycle, unless DR==0, in which case RegW=0 (x0 is never written).
  - Next state is IDLE.
- **FLT:**
  - Fault=1 for one cycle, with RegW=0 and MemReq=0.
  - Next state is IDLE.
- **Start handling:** Start while Busy is ignored (not queued). Start in the same cycle as the return to IDLE is also ignored, because the state is not yet IDLE at that edge.
- **Extraction:**
  - Byte: selected by Addr_q[1:0]; lane 0 = MemRData[7:0].
  - Halfword: selected by Addr_q[1]; lane 0 = MemRData[15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- **Latency:**
  - Start at edge 0 gives MemReq=1 after edge 0.
  - Ack sampled at edge k gives RegW=1 after edge k, for one cycle.
  - Minimum Start-to-RegW is 2 cycles.
- **Outside write cycles:** DR and Reg_In keep their last values when RegW=0; the register file must ignore them.
- **Counter:** clears on entry to REQ; it never wraps, because the timeout fires first.

Test Plan:
- **Aligned LW:** Start, LW, Addr=0x100, Rd=5; MemAck on the 3rd REQ cycle with MemRData=0xDEADBEEF.
  - Expect MemAddr=0x100, then RegW=1, DR=5, Reg_In=0xDEADBEEF for one cycle.
  - Expect Busy to fall the cycle after.
- **Byte lanes:** MemRData=0x80FF7F01.
  - LB at Addr 0x203 gives Reg_In=0xFFFFFF80; LBU at 0x203 gives 0x00000080.
  - LB at 0x201 gives 0x0000007F; LHU at 0x202 gives 0x000080FF; LH at 0x202 gives 0xFFFF80FF.
- **Faults, no memory access:**
  - LW at Addr 0x102 gives Fault=1 one cycle after Start, with MemReq never asserted and RegW=0.
  - LH at 0x101 and Funct3=011 give the same response.
- **Timeout:** TIMEOUT=4, MemAck held at 0.
  - Expect MemReq=1 for exactly 4 cycles, then Fault=1, RegW=0, then Busy=0.
  - Ack on the 4th REQ cycle instead gives a normal WB with no Fault.
- **x0 and back-pressure:**
  - LW with Rd=0 and MemAck=1 gives RegW=0 and no Fault.
  - A second Start asserted while in REQ is ignored: exactly one memory request is issued.
- **Async reset:** pull RST_N low mid-REQ.
  - Expect MemReq and Busy to drop immediately, with no RegW and no Fault after release.
  - A new LW completes normally afterwards.
